// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate controller: immediate
// generator select codes, RV64 major opcodes and the skid-buffer state enum.
package imm_pkg;

    // Immediate generator select; the value 7 is never produced.
    localparam logic [2:0] IMM_ZERO = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_CSR  = 3'd6;

    // RV64 major opcodes (inst[6:0]).
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Occupancy of the HEAD/SKID pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/imm_op_decode.sv
// Combinational opcode classifier: maps opcode/funct3 to the immediate
// generator select and flags encodings the decode stage cannot handle.
module imm_op_decode
    import imm_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output logic [2:0] o_immgen_op,
    output logic       o_illegal
);

    // Classify the opcode; anything unlisted (including 16-bit forms) is illegal.
    always_comb begin
        o_immgen_op = IMM_ZERO;
        o_illegal   = 1'b0;
        if (i_opcode[1:0] != 2'b11) begin
            o_illegal = 1'b1;
        end else begin
            case (i_opcode)
                OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: o_immgen_op = IMM_I;
                OPC_STORE:                                    o_immgen_op = IMM_S;
                OPC_BRANCH:                                   o_immgen_op = IMM_B;
                OPC_LUI, OPC_AUIPC:                           o_immgen_op = IMM_U;
                OPC_JAL:                                      o_immgen_op = IMM_J;
                OPC_OP, OPC_OP_32:                            o_immgen_op = IMM_ZERO;
                OPC_SYSTEM: begin
                    case (i_funct3)
                        3'b000:                 o_immgen_op = IMM_ZERO;
                        3'b001, 3'b010, 3'b011: o_immgen_op = IMM_I;
                        3'b101, 3'b110, 3'b111: o_immgen_op = IMM_CSR;
                        default:                o_illegal   = 1'b1;
                    endcase
                end
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: two-entry skid buffer (HEAD/SKID) in front of the
// immediate generator. Classification happens at push time so the outputs
// come straight from registers; in_ready depends only on the state register.
module imm_decode_ctrl
    import imm_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_immgen_op,
    output logic            out_illegal,
    output logic [31:0]     stall_cnt
);

    state_t          r_state;
    state_t          w_state_next;

    logic [ILEN-1:0] r_head_inst, r_skid_inst;
    logic [XLEN-1:0] r_head_pc,   r_skid_pc;
    logic [2:0]      r_head_op,   r_skid_op;
    logic            r_head_ill,  r_skid_ill;
    logic [31:0]     r_stall_cnt;

    logic [2:0]      w_dec_op;
    logic            w_dec_ill;
    logic            w_push, w_pop;
    logic            w_head_from_in, w_head_from_skid, w_skid_from_in;

    imm_op_decode u_dec (
        .i_opcode    (in_inst[6:0]),
        .i_funct3    (in_inst[14:12]),
        .o_immgen_op (w_dec_op),
        .o_illegal   (w_dec_ill)
    );

    assign in_ready  = !rst && (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    // Next-state and data-move selection; flush overrides push and pop.
    always_comb begin
        w_state_next     = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_next   = ST_ONE;
                        w_head_from_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_from_in = 1'b1;
                    end else if (w_push) begin
                        w_state_next   = ST_TWO;
                        w_skid_from_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_next   = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_next     = ST_ONE;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_next;
    end

    // HEAD/SKID entry storage; contents survive a flush, only validity drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_inst <= '0;
            r_head_pc   <= '0;
            r_head_op   <= IMM_ZERO;
            r_head_ill  <= 1'b0;
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
            r_skid_op   <= IMM_ZERO;
            r_skid_ill  <= 1'b0;
        end else begin
            if (w_head_from_in) begin
                r_head_inst <= in_inst;
                r_head_pc   <= in_pc;
                r_head_op   <= w_dec_op;
                r_head_ill  <= w_dec_ill;
            end else if (w_head_from_skid) begin
                r_head_inst <= r_skid_inst;
                r_head_pc   <= r_skid_pc;
                r_head_op   <= r_skid_op;
                r_head_ill  <= r_skid_ill;
            end
            if (w_skid_from_in) begin
                r_skid_inst <= in_inst;
                r_skid_pc   <= in_pc;
                r_skid_op   <= w_dec_op;
                r_skid_ill  <= w_dec_ill;
            end
        end
    end

    // Saturating count of cycles where the head waits on the ID datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign out_inst      = r_head_inst;
    assign out_pc        = r_head_pc;
    assign out_immgen_op = r_head_op;
    assign out_illegal   = r_head_ill;
    assign stall_cnt     = r_stall_cnt;

endmodule
